// File: rtl/tlb_ptw.sv
`default_nettype none
// ============================================================================
// Module   : tlb_ptw
// Brief    : Sv32 page-table walker; resolves a TLB miss into one TLB fill or a fault.
// Revision : 1.0
// ============================================================================
module tlb_ptw #(
    parameter int TLB_WIDTH = 52,
    parameter int TLB_DEPTH = 32,
    parameter int PA_WIDTH  = 34
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_miss_req,
    input  logic [19:0]                  i_miss_vpn,
    input  logic [21:0]                  i_satp_ppn,
    input  logic                         i_flush,
    output logic                         o_mem_req,
    output logic [PA_WIDTH-1:0]          o_mem_addr,
    input  logic                         i_mem_ack,
    input  logic [31:0]                  i_mem_rdata,
    input  logic                         i_mem_err,
    output logic                         o_tlb_we,
    output logic [$clog2(TLB_DEPTH)-1:0] o_tlb_waddr,
    output logic [TLB_WIDTH-1:0]         o_tlb_wdata,
    output logic                         o_busy,
    output logic                         o_walk_done,
    output logic                         o_page_fault,
    output logic                         o_access_fault
);

    localparam int VP_W = $clog2(TLB_DEPTH);
    localparam logic [VP_W-1:0] c_LAST_SLOT = VP_W'(TLB_DEPTH - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_L1    = 3'd1;
    localparam logic [2:0] c_L0    = 3'd2;
    localparam logic [2:0] c_FILL  = 3'd3;
    localparam logic [2:0] c_FAULT = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [19:0]     r_vpn;
    logic [31:1]     r_pte;
    logic [21:0]     r_ppn;
    logic [VP_W-1:0] r_victim;
    logic            r_acc_fault;
    logic            w_acc_fault;
    logic            w_pte_valid;
    logic            w_pte_leaf;
    logic            w_pte_misal;

    // Reserved W-without-R encoding is treated exactly like an invalid PTE.
    assign w_pte_valid = i_mem_rdata[0] && !(i_mem_rdata[2] && !i_mem_rdata[1]);
    assign w_pte_leaf  = i_mem_rdata[1] || i_mem_rdata[3];
    assign w_pte_misal = |i_mem_rdata[19:10];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_acc_fault = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (i_miss_req) w_next = c_L1;
            end
            c_L1: begin
                if (i_mem_ack) begin
                    if (i_mem_err) begin
                        w_next      = c_FAULT;
                        w_acc_fault = 1'b1;
                    end else if (!w_pte_valid) begin
                        w_next = c_FAULT;
                    end else if (w_pte_leaf) begin
                        w_next = w_pte_misal ? c_FAULT : c_FILL;
                    end else begin
                        w_next = c_L0;
                    end
                end
            end
            c_L0: begin
                if (i_mem_ack) begin
                    if (i_mem_err) begin
                        w_next      = c_FAULT;
                        w_acc_fault = 1'b1;
                    end else if (!w_pte_valid || !w_pte_leaf) begin
                        w_next = c_FAULT;
                    end else begin
                        w_next = c_FILL;
                    end
                end
            end
            default: w_next = c_IDLE;
        endcase
        if (i_flush) w_next = c_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vpn       <= '0;
            r_pte       <= '0;
            r_ppn       <= '0;
            r_victim    <= '0;
            r_acc_fault <= 1'b0;
        end else begin
            if (i_flush) begin
                r_victim <= '0;
            end else if (r_state == c_FILL) begin
                r_victim <= (r_victim == c_LAST_SLOT) ? '0 : r_victim + 1'b1;
            end
            if (r_state == c_IDLE && i_miss_req && !i_flush) begin
                r_vpn <= i_miss_vpn;
            end
            if (i_mem_ack && (r_state == c_L1 || r_state == c_L0)) begin
                r_pte <= i_mem_rdata[31:1];
                // Superpage leaves splice the low VPN bits into the PPN.
                r_ppn <= (r_state == c_L1) ? {i_mem_rdata[31:20], r_vpn[9:0]}
                                           : i_mem_rdata[31:10];
            end
            if (w_next == c_FAULT) begin
                r_acc_fault <= w_acc_fault;
            end
        end
    end

    always_comb begin
        o_mem_req      = 1'b0;
        o_mem_addr     = '0;
        o_tlb_we       = 1'b0;
        o_tlb_wdata    = '0;
        o_walk_done    = 1'b0;
        o_page_fault   = 1'b0;
        o_access_fault = 1'b0;
        o_busy         = (r_state != c_IDLE);
        o_tlb_waddr    = r_victim;
        case (r_state)
            c_L1: begin
                o_mem_req  = 1'b1;
                o_mem_addr = PA_WIDTH'({i_satp_ppn, r_vpn[19:10], 2'b00});
            end
            c_L0: begin
                o_mem_req  = 1'b1;
                o_mem_addr = PA_WIDTH'({r_pte[31:10], r_vpn[9:0], 2'b00});
            end
            c_FILL: begin
                // A flush arriving in the fill cycle wins over the write.
                o_tlb_we    = !i_flush;
                o_walk_done = !i_flush;
                o_tlb_wdata = TLB_WIDTH'({r_vpn, r_ppn, r_pte[9:1], 1'b1});
            end
            c_FAULT: begin
                o_walk_done    = !i_flush;
                o_access_fault = !i_flush && r_acc_fault;
                o_page_fault   = !i_flush && !r_acc_fault;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tlb_ptw.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_ptw
// Brief    : Scoreboard bench for tlb_ptw with a PTE memory responder.
// Revision : 1.0
// ============================================================================
module tb_tlb_ptw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req;
    logic [19:0] miss_vpn;
    logic [21:0] satp;
    logic        flush;
    logic        mem_req;
    logic [33:0] mem_addr;
    logic        mem_ack;
    logic        rsp_ack;
    logic        inj_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        tlb_we;
    logic [4:0]  tlb_waddr;
    logic [51:0] tlb_wdata;
    logic        busy;
    logic        walk_done;
    logic        page_fault;
    logic        access_fault;

    assign mem_ack = rsp_ack | inj_ack;

    always #5 clk = ~clk;

    tlb_ptw dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_miss_req     (miss_req),
        .i_miss_vpn     (miss_vpn),
        .i_satp_ppn     (satp),
        .i_flush        (flush),
        .o_mem_req      (mem_req),
        .o_mem_addr     (mem_addr),
        .i_mem_ack      (mem_ack),
        .i_mem_rdata    (mem_rdata),
        .i_mem_err      (mem_err),
        .o_tlb_we       (tlb_we),
        .o_tlb_waddr    (tlb_waddr),
        .o_tlb_wdata    (tlb_wdata),
        .o_busy         (busy),
        .o_walk_done    (walk_done),
        .o_page_fault   (page_fault),
        .o_access_fault (access_fault)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [51:0] wdata;
        logic        pf;
        logic        af;
        int          lat;
    } res_t;

    res_t        exp_q[$];
    logic [33:0] addr_q[$];
    logic [32:0] rsp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          miss_cyc = 0;
    int          ack_delay = 0;
    int          exp_victim = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: checks each request address and its stability, acks after ack_delay.
    initial begin : responder
        int          wcnt;
        logic        in_req;
        logic [33:0] held;
        logic [32:0] r;
        wcnt = 0; in_req = 1'b0; held = '0;
        rsp_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
            if (!rst_n || !mem_req) begin
                in_req = 1'b0;
            end else begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wcnt   = 0;
                    held   = mem_addr;
                    check("req_expected", 64'(addr_q.size() > 0), 64'd1);
                    if (addr_q.size() > 0) check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
                end else begin
                    check("addr_stable", 64'(mem_addr), 64'(held));
                end
                if (wcnt >= ack_delay) begin
                    check("rsp_available", 64'(rsp_q.size() > 0), 64'd1);
                    r         = (rsp_q.size() > 0) ? rsp_q.pop_front() : 33'd0;
                    rsp_ack   = 1'b1;
                    mem_err   = r[32];
                    mem_rdata = r[31:0];
                    in_req    = 1'b0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Output monitor: every walk_done/tlb_we is matched against the scoreboard.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (walk_done || tlb_we)) begin
                check("done_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("walk_done", 64'(walk_done), 64'd1);
                    check("tlb_we", 64'(tlb_we), 64'(e.we));
                    check("page_fault", 64'(page_fault), 64'(e.pf));
                    check("access_fault", 64'(access_fault), 64'(e.af));
                    check("latency", 64'(cyc - miss_cyc + 1), 64'(e.lat));
                    if (e.we) begin
                        check("tlb_waddr", 64'(tlb_waddr), 64'(e.waddr));
                        check("tlb_wdata", 64'(tlb_wdata), 64'(e.wdata));
                    end
                end
            end
        end
    end

    function automatic logic pte_ok(input logic [31:0] p);
        return p[0] && !(p[2] && !p[1]);
    endfunction

    task automatic start_walk(input logic [19:0] vpn, input logic [21:0] sp,
                              input logic [31:0] p1, input logic e1,
                              input logic [31:0] p2, input logic e2, input bit expect_result);
        res_t        r;
        int          lv;
        logic [21:0] ppn;
        r.we = 1'b0; r.pf = 1'b0; r.af = 1'b0; r.wdata = '0;
        r.waddr = 5'(exp_victim);
        lv = 1;
        addr_q.push_back({sp, vpn[19:10], 2'b00});
        rsp_q.push_back({e1, p1});
        if (e1) r.af = 1'b1;
        else if (!pte_ok(p1)) r.pf = 1'b1;
        else if (p1[1] || p1[3]) begin
            if (p1[19:10] != 10'd0) r.pf = 1'b1;
            else begin
                r.we    = 1'b1;
                ppn     = {p1[31:20], vpn[9:0]};
                r.wdata = {vpn, ppn, p1[9:0] | 10'h001};
            end
        end else begin
            lv = 2;
            addr_q.push_back({p1[31:10], vpn[9:0], 2'b00});
            rsp_q.push_back({e2, p2});
            if (e2) r.af = 1'b1;
            else if (!pte_ok(p2) || !(p2[1] || p2[3])) r.pf = 1'b1;
            else begin
                r.we    = 1'b1;
                r.wdata = {vpn, p2[31:10], p2[9:0] | 10'h001};
            end
        end
        r.lat = lv * (ack_delay + 1) + 1;
        if (expect_result) begin
            exp_q.push_back(r);
            if (r.we) exp_victim = (exp_victim + 1) % 32;
        end
        @(negedge clk);
        miss_vpn = vpn; satp = sp; miss_req = 1'b1;
        miss_cyc = cyc + 1;
        @(negedge clk);
        miss_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("walk_timeout", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic drain_check();
        check("addr_q_drained", 64'(addr_q.size()), 64'd0);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] p;
        rst_n = 1'b0; miss_req = 1'b0; miss_vpn = '0; satp = '0; flush = 1'b0; inj_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tlb_we", 64'(tlb_we), 64'd0);
        check("rst_waddr", 64'(tlb_waddr), 64'd0);
        check("rst_wdata", 64'(tlb_wdata), 64'd0);
        check("rst_done_flags", 64'({walk_done, page_fault, access_fault}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4 KB page then superpage, immediate ack
        start_walk(20'h12345, 22'h00010, 32'h00020001, 1'b0, 32'h00ABC0CF, 1'b0, 1'b1);
        wait_idle();
        start_walk(20'h00403, 22'h00010, 32'h1230000F, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        drain_check();

        // Faults: invalid, misaligned superpage, L0 bus error, W without R, L0 non-leaf
        start_walk(20'h00001, 22'h00020, 32'h00000000, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        start_walk(20'h00002, 22'h00020, 32'h00000C0B, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        start_walk(20'h12345, 22'h00010, 32'h00020001, 1'b0, 32'h00ABC0CF, 1'b1, 1'b1);
        wait_idle();
        start_walk(20'h00003, 22'h00020, 32'h00000005, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        start_walk(20'h00004, 22'h00020, 32'h00040001, 1'b0, 32'h00030001, 1'b0, 1'b1);
        wait_idle();
        drain_check();

        // Wait states, with a spurious miss_req while busy
        ack_delay = 5;
        start_walk(20'hABCDE, 22'h3FFFF, 32'h00123401, 1'b0, 32'h0FEDC0C7, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        miss_vpn = 20'hFFFFF; miss_req = 1'b1;
        repeat (2) @(negedge clk);
        miss_req = 1'b0;
        wait_idle();
        ack_delay = 0;
        drain_check();

        // Round robin: flush, 33 walks, then 4 more, flush, one more
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        exp_victim = 0;
        for (int i = 0; i < 37; i++) begin
            p = {12'($urandom), 10'h000, 10'h0CF};
            if (i % 3 == 0)
                start_walk(20'($urandom), 22'($urandom), 32'h00050001, 1'b0, p, 1'b0, 1'b1);
            else
                start_walk(20'($urandom), 22'($urandom), p, 1'b0, 32'h0, 1'b0, 1'b1);
            wait_idle();
        end
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        exp_victim = 0;
        start_walk(20'h11111, 22'h00100, 32'h2220000F, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        drain_check();

        // Flush in the FILL cycle
        start_walk(20'h12345, 22'h00010, 32'h00020001, 1'b0, 32'h00ABC0CF, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("flush_fill_we", 64'(tlb_we), 64'd0);
        check("flush_fill_done", 64'(walk_done), 64'd0);
        @(posedge clk); #1 flush = 1'b0;
        wait_idle();
        exp_victim = 0;
        drain_check();

        // Flush during an L1 wait, then a late ack in IDLE
        ack_delay = 50;
        start_walk(20'h22222, 22'h00200, 32'h3330000F, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        check("flush_mem_req", 64'(mem_req), 64'd0);
        inj_ack = 1'b1; @(negedge clk); inj_ack = 1'b0;
        @(negedge clk);
        check("late_ack_busy", 64'(busy), 64'd0);
        rsp_q.delete();
        ack_delay = 0;
        exp_victim = 0;
        start_walk(20'h33333, 22'h00300, 32'h4440000F, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        drain_check();

        // Asynchronous reset in the middle of L0
        ack_delay = 10;
        start_walk(20'h12345, 22'h00010, 32'h00020001, 1'b0, 32'h00ABC0CF, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        @(posedge clk); #2;
        check("pre_rst_mem_req", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", 64'(mem_req), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_outs", 64'({tlb_we, walk_done, page_fault, access_fault}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        addr_q.delete(); rsp_q.delete();
        ack_delay = 0;
        exp_victim = 0;
        start_walk(20'h44444, 22'h00400, 32'h5550000F, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        drain_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
